// File: rtl/branch_nzp_unit.sv
// Per-thread branch unit: latches N/Z/P compare flags, resolves BRnzp and owns the PC.
// Optional taken-branch counter enabled by defining BRANCH_STATS_EN.
//
// state | meaning
// RUN   | accepting ops whenever enable is high
// HALT  | HALT op accepted; only reset returns to RUN
module branch_nzp_unit #(
  parameter int                  PC_WIDTH = 8,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                op_valid,
  output logic                op_ready,
  input  logic [1:0]          op_code,
  input  logic [2:0]          cmp_nzp,
  input  logic [2:0]          br_mask,
  input  logic [PC_WIDTH-1:0] br_target,
  output logic [PC_WIDTH-1:0] pc,
  output logic [2:0]          nzp,
  output logic                br_taken,
  output logic                halted,
  output logic [15:0]         taken_count
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_t;

  localparam logic [1:0] OP_SEQ  = 2'b00;
  localparam logic [1:0] OP_CMP  = 2'b01;
  localparam logic [1:0] OP_BR   = 2'b10;
  localparam logic [1:0] OP_HALT = 2'b11;

  state_t              state;
  logic                accept;
  logic                br_hit;
  logic [PC_WIDTH-1:0] pc_inc;

  assign op_ready = enable & (state == RUN);
  assign accept   = op_valid & op_ready;
  // Resolved against the registered flags; a CMP one cycle earlier is already visible.
  assign br_hit   = |(br_mask & nzp);
  assign pc_inc   = pc + PC_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      pc       <= RESET_PC;
      nzp      <= 3'b000;
      br_taken <= 1'b0;
      halted   <= 1'b0;
    end else begin
      br_taken <= 1'b0;
      if (accept) begin
        case (op_code)
          OP_SEQ: pc <= pc_inc;
          OP_CMP: begin
            nzp <= cmp_nzp;
            pc  <= pc_inc;
          end
          OP_BR: begin
            if (br_hit) begin
              pc       <= br_target;
              br_taken <= 1'b1;
            end else begin
              pc <= pc_inc;
            end
          end
          OP_HALT: begin
            state  <= HALT;
            halted <= 1'b1;
          end
          default: pc <= pc;
        endcase
      end
    end
  end

`ifdef BRANCH_STATS_EN
  logic [15:0] taken_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      taken_cnt <= 16'h0000;
    end else if (accept && (op_code == OP_BR) && br_hit && (taken_cnt != 16'hFFFF)) begin
      taken_cnt <= taken_cnt + 16'd1;
    end
  end

  assign taken_count = taken_cnt;
`else
  assign taken_count = 16'h0000;
`endif

endmodule

// File: tb/tb_branch_nzp_unit.sv
// Directed, table-driven bench for branch_nzp_unit (PC_WIDTH 8, RESET_PC 0).
// Expected taken_count follows BRANCH_STATS_EN when the bench is built with it.
module tb_branch_nzp_unit;

  typedef struct {
    logic       rst;
    logic       en;
    logic       vld;
    logic [1:0] op;
    logic [2:0] cmp;
    logic [2:0] mask;
    logic [7:0] tgt;
    logic [7:0] epc;
    logic [2:0] enzp;
    logic       ebt;
    logic       ehalt;
    logic       erdy;
    logic [15:0] etc;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset, enable, op_valid, op_ready;
  logic [1:0] op_code;
  logic [2:0] cmp_nzp, br_mask;
  logic [7:0] br_target, pc;
  logic [2:0] nzp;
  logic       br_taken, halted;
  logic [15:0] taken_count;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t vecs[$];

  always #5 clk = ~clk;

  branch_nzp_unit #(.PC_WIDTH(8), .RESET_PC(8'h00)) dut (
    .clk(clk), .reset(reset), .enable(enable), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .cmp_nzp(cmp_nzp), .br_mask(br_mask), .br_target(br_target),
    .pc(pc), .nzp(nzp), .br_taken(br_taken), .halted(halted), .taken_count(taken_count)
  );

  task automatic check(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_count(input logic [15:0] c);
`ifdef BRANCH_STATS_EN
    return c;
`else
    return 16'h0000;
`endif
  endfunction

  initial begin
    reset = 1'b1; enable = 1'b1; op_valid = 1'b0; op_code = 2'b00;
    cmp_nzp = 3'b000; br_mask = 3'b000; br_target = 8'h00;

    //           rst  en   vld  op     cmp     mask    tgt    pc     nzp     bt   h    rdy  cnt
    vecs.push_back('{1'b1,1'b1,1'b0,2'b00,3'b000,3'b000,8'h00, 8'h00,3'b000,1'b0,1'b0,1'b1,16'd0}); // 0 reset
    vecs.push_back('{1'b0,1'b1,1'b1,2'b00,3'b000,3'b000,8'h00, 8'h01,3'b000,1'b0,1'b0,1'b1,16'd0}); // SEQ
    vecs.push_back('{1'b0,1'b1,1'b1,2'b00,3'b000,3'b000,8'h00, 8'h02,3'b000,1'b0,1'b0,1'b1,16'd0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b00,3'b000,3'b000,8'h00, 8'h03,3'b000,1'b0,1'b0,1'b1,16'd0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b10,3'b000,3'b111,8'h40, 8'h04,3'b000,1'b0,1'b0,1'b1,16'd0}); // BR 111, nzp 000
    vecs.push_back('{1'b0,1'b1,1'b1,2'b01,3'b100,3'b000,8'h00, 8'h05,3'b100,1'b0,1'b0,1'b1,16'd0}); // CMP 100
    vecs.push_back('{1'b0,1'b1,1'b1,2'b10,3'b000,3'b100,8'h40, 8'h40,3'b100,1'b1,1'b0,1'b1,16'd1}); // BR taken
    vecs.push_back('{1'b0,1'b1,1'b1,2'b00,3'b000,3'b000,8'h00, 8'h41,3'b100,1'b0,1'b0,1'b1,16'd1}); // pulse ends
    vecs.push_back('{1'b0,1'b1,1'b1,2'b01,3'b010,3'b000,8'h00, 8'h42,3'b010,1'b0,1'b0,1'b1,16'd1}); // CMP 010
    vecs.push_back('{1'b0,1'b1,1'b1,2'b10,3'b000,3'b101,8'h40, 8'h43,3'b010,1'b0,1'b0,1'b1,16'd1}); // BR 101 not taken
    vecs.push_back('{1'b0,1'b1,1'b1,2'b10,3'b000,3'b000,8'h80, 8'h44,3'b010,1'b0,1'b0,1'b1,16'd1}); // mask 000
    vecs.push_back('{1'b0,1'b1,1'b1,2'b10,3'b000,3'b111,8'h80, 8'h80,3'b010,1'b1,1'b0,1'b1,16'd2}); // mask 111 taken
    for (int i = 0; i < 5; i++)                                                                       // disabled x5
      vecs.push_back('{1'b0,1'b0,1'b1,2'b00,3'b000,3'b000,8'h00, 8'h80,3'b010,1'b0,1'b0,1'b0,16'd2});
    vecs.push_back('{1'b0,1'b1,1'b0,2'b00,3'b000,3'b000,8'h00, 8'h80,3'b010,1'b0,1'b0,1'b1,16'd2}); // idle
    vecs.push_back('{1'b0,1'b1,1'b1,2'b10,3'b000,3'b010,8'hFE, 8'hFE,3'b010,1'b1,1'b0,1'b1,16'd3}); // taken to FE
    vecs.push_back('{1'b0,1'b1,1'b1,2'b00,3'b000,3'b000,8'h00, 8'hFF,3'b010,1'b0,1'b0,1'b1,16'd3});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b00,3'b000,3'b000,8'h00, 8'h00,3'b010,1'b0,1'b0,1'b1,16'd3}); // wrap
    vecs.push_back('{1'b0,1'b1,1'b1,2'b11,3'b000,3'b000,8'h00, 8'h00,3'b010,1'b0,1'b1,1'b0,16'd3}); // HALT
    vecs.push_back('{1'b0,1'b1,1'b1,2'b00,3'b000,3'b000,8'h00, 8'h00,3'b010,1'b0,1'b1,1'b0,16'd3}); // SEQ ignored
    vecs.push_back('{1'b0,1'b1,1'b1,2'b01,3'b001,3'b000,8'h00, 8'h00,3'b010,1'b0,1'b1,1'b0,16'd3}); // CMP ignored
    vecs.push_back('{1'b1,1'b1,1'b1,2'b00,3'b000,3'b000,8'h00, 8'h00,3'b000,1'b0,1'b0,1'b1,16'd0}); // reset from HALT
    vecs.push_back('{1'b0,1'b1,1'b1,2'b00,3'b000,3'b000,8'h00, 8'h01,3'b000,1'b0,1'b0,1'b1,16'd0});
    vecs.push_back('{1'b0,1'b1,1'b1,2'b01,3'b001,3'b000,8'h00, 8'h02,3'b001,1'b0,1'b0,1'b1,16'd0});
    vecs.push_back('{1'b1,1'b1,1'b1,2'b10,3'b000,3'b001,8'h77, 8'h00,3'b000,1'b0,1'b0,1'b1,16'd0}); // reset on accept
    vecs.push_back('{1'b0,1'b1,1'b1,2'b10,3'b000,3'b001,8'h77, 8'h01,3'b000,1'b0,1'b0,1'b1,16'd0}); // nzp 000 not taken

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      reset = vecs[i].rst; enable = vecs[i].en; op_valid = vecs[i].vld; op_code = vecs[i].op;
      cmp_nzp = vecs[i].cmp; br_mask = vecs[i].mask; br_target = vecs[i].tgt;
      @(posedge clk);
      #1;
      check("pc",          i, 32'(pc),          32'(vecs[i].epc));
      check("nzp",         i, 32'(nzp),         32'(vecs[i].enzp));
      check("br_taken",    i, 32'(br_taken),    32'(vecs[i].ebt));
      check("halted",      i, 32'(halted),      32'(vecs[i].ehalt));
      check("op_ready",    i, 32'(op_ready),    32'(vecs[i].erdy));
      check("taken_count", i, 32'(taken_count), 32'(exp_count(vecs[i].etc)));
    end

    // op_ready follows enable combinationally, with no clock edge in between.
    @(negedge clk);
    op_valid = 1'b0; reset = 1'b0;
    enable = 1'b0; #1;
    check("ready_comb_lo", 100, 32'(op_ready), 32'd0);
    enable = 1'b1; #1;
    check("ready_comb_hi", 101, 32'(op_ready), 32'd1);

    // Back-to-back CMP then BR: the BR sees the flags latched one edge earlier.
    @(negedge clk);
    op_valid = 1'b1; op_code = 2'b01; cmp_nzp = 3'b001;
    @(negedge clk);
    op_code = 2'b10; br_mask = 3'b001; br_target = 8'h5A;
    @(posedge clk); #1;
    check("b2b_pc", 102, 32'(pc), 32'h5A);
    check("b2b_bt", 103, 32'(br_taken), 32'd1);
    check("b2b_cnt", 104, 32'(taken_count), 32'(exp_count(16'd1)));
    @(negedge clk);
    op_valid = 1'b0;
    @(posedge clk); #1;
    check("b2b_pulse_end", 105, 32'(br_taken), 32'd0);
    check("b2b_pc_hold", 106, 32'(pc), 32'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
